// File: rtl/lsu_pkg.sv
// lsu_pkg -- shared types and helpers for the load/store stage.
//   state_t  : stage FSM states (IDLE, WAIT, RESP)
//   size_t   : access size encoding (BYTE, HALF, WORD)
//   DEFAULT_TIMEOUT_CYC : default WAIT cycle budget before a bus-error abort
//   lane_replicate / lane_strobe : store lane formatting helpers
package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_t;

   localparam int unsigned DEFAULT_TIMEOUT_CYC = 32'd255;

   // Copy the store operand into every lane it could target, so the
   // strobe alone decides which bytes the memory actually writes.
   function automatic logic [31:0] lane_replicate(input size_t sz, input logic [31:0] d);
      logic [31:0] r;
      case (sz)
         SZ_BYTE: r = {4{d[7:0]}};
         SZ_HALF: r = {2{d[15:0]}};
         SZ_WORD: r = d;
         default: r = d;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] lane_strobe(input size_t sz, input logic [1:0] off);
      logic [3:0] r;
      case (sz)
         SZ_BYTE: r = 4'b0001 << off;
         SZ_HALF: r = 4'b0011 << off;
         SZ_WORD: r = 4'b1111;
         default: r = 4'b0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/load_align.sv
// load_align -- combinational load data formatter.
//   rdata    : raw 32-bit word from memory
//   off      : byte offset of the access within the word
//   size     : access size (BYTE/HALF/WORD)
//   sign_ext : 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu)
//   data     : right-justified, extended load result
module load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  size_t       size,
   input  logic        sign_ext,
   output logic [31:0] data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane select: the addressed byte and the addressed halfword.
   always_comb begin
      case (off)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = rdata[7:0];
      endcase
      if (off[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // Extension to 32 bits according to size and signedness.
   always_comb begin
      case (size)
         SZ_BYTE: data = {{24{sign_ext & byte_s[7]}}, byte_s};
         SZ_HALF: data = {{16{sign_ext & half_s[15]}}, half_s};
         SZ_WORD: data = rdata;
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu_stage.sv
// lsu_stage -- single-outstanding load/store unit pipeline stage.
//   clk, rst_n        : clock, async active-low reset
//   addr_in           : effective address
//   store_data        : store operand
//   lb_en..sw_en      : one-hot access request
//   rd_in             : load destination register
//   mem_req/mem_we    : memory request / write qualifier
//   mem_addr          : word-aligned address; mem_wdata/mem_wstrb: store lanes
//   mem_rdata/mem_ready : read data / access complete
//   stall             : freeze upstream (combinational)
//   wb_valid/wb_rd/wb_data : load writeback (one-cycle)
//   misalign_err/bus_err   : one-cycle exception pulses
module lsu_stage
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data,
   input  logic        lb_en,
   input  logic        lh_en,
   input  logic        lw_en,
   input  logic        lbu_en,
   input  logic        lhu_en,
   input  logic        sb_en,
   input  logic        sh_en,
   input  logic        sw_en,
   input  logic [4:0]  rd_in,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 32'd1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 32'd1);

   state_t        state_r, state_d;
   logic [CW-1:0] cnt_r;
   logic [1:0]    off_r;
   size_t         size_r;
   logic          signed_r;
   logic          store_r;
   logic [4:0]    rd_r;

   logic [7:0]    en_vec_s;
   size_t         req_size_s;
   logic          req_signed_s;
   logic          req_store_s;
   logic          aligned_s;
   logic          legal_s;
   logic          illegal_s;
   logic          accept_s;
   logic          reject_s;
   logic          done_load_s;
   logic          done_store_s;
   logic          timeout_s;
   logic [31:0]   align_data_s;

   // Request decode: size, signedness, direction and legality of this cycle's enables.
   always_comb begin
      en_vec_s     = {lb_en, lh_en, lw_en, lbu_en, lhu_en, sb_en, sh_en, sw_en};
      req_signed_s = lb_en | lh_en;
      req_store_s  = sb_en | sh_en | sw_en;
      if (lh_en | lhu_en | sh_en) begin
         req_size_s = SZ_HALF;
      end else if (lw_en | sw_en) begin
         req_size_s = SZ_WORD;
      end else begin
         req_size_s = SZ_BYTE;
      end
      case (req_size_s)
         SZ_BYTE: aligned_s = 1'b1;
         SZ_HALF: aligned_s = ~addr_in[0];
         SZ_WORD: aligned_s = (addr_in[1:0] == 2'b00);
         default: aligned_s = 1'b0;
      endcase
      legal_s   = $onehot(en_vec_s) && aligned_s;
      illegal_s = (|en_vec_s) && !legal_s;
   end

   // Next-state logic and per-cycle event strobes.
   always_comb begin
      state_d      = state_r;
      accept_s     = 1'b0;
      reject_s     = 1'b0;
      done_load_s  = 1'b0;
      done_store_s = 1'b0;
      timeout_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (legal_s) begin
               accept_s = 1'b1;
               state_d  = ST_WAIT;
            end else if (illegal_s) begin
               reject_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // A ready on the last budgeted cycle still completes normally.
            if (mem_ready) begin
               if (store_r) begin
                  done_store_s = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  done_load_s = 1'b1;
                  state_d     = ST_RESP;
               end
            end else if (cnt_r == CNT_LAST) begin
               timeout_s = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign stall = (state_r != ST_IDLE) || legal_s;

   load_align u_align (
      .rdata    (mem_rdata),
      .off      (off_r),
      .size     (size_r),
      .sign_ext (signed_r),
      .data     (align_data_s)
   );

   // State, latched request and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         off_r        <= 2'b00;
         size_r       <= SZ_BYTE;
         signed_r     <= 1'b0;
         store_r      <= 1'b0;
         rd_r         <= 5'd0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'h0000_0000;
         mem_wdata    <= 32'h0000_0000;
         mem_wstrb    <= 4'b0000;
         wb_valid     <= 1'b0;
         wb_rd        <= 5'd0;
         wb_data      <= 32'h0000_0000;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         state_r      <= state_d;
         misalign_err <= reject_s;
         bus_err      <= timeout_s;
         wb_valid     <= done_load_s;
         if (accept_s) begin
            cnt_r     <= '0;
            off_r     <= addr_in[1:0];
            size_r    <= req_size_s;
            signed_r  <= req_signed_s;
            store_r   <= req_store_s;
            rd_r      <= rd_in;
            mem_req   <= 1'b1;
            mem_we    <= req_store_s;
            mem_addr  <= {addr_in[31:2], 2'b00};
            mem_wdata <= req_store_s ? lane_replicate(req_size_s, store_data) : 32'h0000_0000;
            mem_wstrb <= req_store_s ? lane_strobe(req_size_s, addr_in[1:0]) : 4'b0000;
         end else if (done_load_s || done_store_s || timeout_s) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'b0000;
         end else if (state_r == ST_WAIT) begin
            cnt_r <= cnt_r + CW'(1'b1);
         end
         if (done_load_s) begin
            wb_data <= align_data_s;
            wb_rd   <= rd_r;
         end
      end
   end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning max WAIT cycles before bus-error abort.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port addr_in  input  32  effective address (ALU result RS1+imm).
REQ-005 SHALL have port store_data  input  32  RS2 value for stores.
REQ-006 SHALL have ports lb_en, lh_en, lw_en, lbu_en, lhu_en, sb_en, sh_en, sw_en  input  1 each  one-hot access request.
REQ-007 SHALL have port rd_in  input  5  load destination register.
REQ-008 SHALL have ports mem_req / mem_we  output  1 each  memory request, write qualifier.
REQ-009 SHALL have ports mem_addr  output  32 (word-aligned, [1:0]=0); mem_wdata  output  32; mem_wstrb  output  4.
REQ-010 SHALL have ports mem_rdata  input  32; mem_ready  input  1  access complete (rdata valid same cycle).
REQ-011 SHALL have port stall  output  1  freeze upstream pipeline.
REQ-012 SHALL have ports wb_valid  output  1; wb_rd  output  5; wb_data  output  32  load writeback.
REQ-013 SHALL have ports misalign_err / bus_err  output  1 each  single-cycle exception pulses.

Function
REQ-014 FSM states SHALL be IDLE, WAIT, RESP.
REQ-015 IDLE, exactly one enable high, aligned: latch word address, byte offset, size, sign, rd, store lanes; go to WAIT.
REQ-016 Alignment: halfword needs addr_in[0]=0; word needs addr_in[1:0]=0; bytes always aligned.
REQ-017 Misaligned or more than one enable high in IDLE: misalign_err pulses next cycle, no memory access, stay IDLE.
REQ-018 stall SHALL be combinational: 1 in IDLE when any enable high and access legal, 1 in WAIT and RESP, else 0.
REQ-019 WAIT: mem_req=1 with mem_addr/mem_we/mem_wdata/mem_wstrb held constant until mem_ready sampled high.
REQ-020 Stores: mem_wdata = store data replicated per lane (byte x4, half x2); mem_wstrb = 0001<<off (sb), 0011<<off (sh), 1111 (sw).
REQ-021 Loads: mem_we=0, mem_wstrb=0000.
REQ-022 mem_ready in WAIT: load -> capture extracted data, go RESP; store -> go IDLE (no wb_valid).
REQ-023 RESP lasts exactly one cycle: wb_valid=1, wb_rd=latched rd, wb_data valid; then IDLE.
REQ-024 Load extraction: lb/lh sign-extend, lbu/lhu zero-extend, selected by latched offset.
REQ-025 Minimum latency: enable at cycle 0, mem_req cycles 1..n, wb_valid at n+1 when mem_ready at n.
REQ-026 WAIT cycle counter SHALL clear on WAIT entry; reaching TIMEOUT_CYC without mem_ready: drop mem_req, pulse bus_err, go IDLE.
REQ-027 mem_ready outside WAIT SHALL be ignored.
REQ-028 Enables arriving while not IDLE SHALL be ignored (upstream is stalled).

Reset
REQ-029 rst_n low SHALL force IDLE asynchronously; mem_req, mem_we, wb_valid, misalign_err, bus_err = 0; mem_addr, mem_wdata, wb_data = 0; mem_wstrb = 0000; wb_rd = 0; counter = 0.
REQ-030 Reset mid-WAIT SHALL abandon the access; no wb_valid or error follows deassertion.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum, access-size encoding (BYTE/HALF/WORD) and default TIMEOUT_CYC.
REQ-032 Combinational sub-module load_align SHALL perform lane select and sign/zero extension.

Verification
REQ-033 lw addr 0x100, mem_rdata 0xDEADBEEF, ready after 2 WAIT cycles -> mem_addr 0x100, wb_data 0xDEADBEEF, wb_valid one cycle after ready.
REQ-034 lb addr 0x203, rdata 0x80112233 -> wb_data 0xFFFFFF80; lbu same -> 0x00000080.
REQ-035 sh addr 0x302, store_data 0x0000ABCD -> mem_wdata 0xABCDABCD, mem_wstrb 1100, mem_addr 0x300, no wb_valid.
REQ-036 lw addr 0x101 -> misalign_err one pulse, mem_req never asserted, stall 0 next cycle.
REQ-037 sw, mem_ready held low, TIMEOUT_CYC=4 -> mem_req 4 cycles, then bus_err pulse, IDLE.
REQ-038 rst_n low during WAIT -> mem_req 0 immediately; later mem_ready pulse produces no wb_valid.
